// File: rtl/fifo_scoreboard_chk_if.sv
// Observed FIFO traffic: push/pop strobes, their data, and the FIFO's status flags.
// vld_in/vld_out are already-accepted transfers: one transfer per asserted cycle, no back-pressure.
interface fifo_scoreboard_chk_if #(
  parameter int DATA_W = 8
);
  logic              vld_in;
  logic [DATA_W-1:0] data_in;
  logic              vld_out;
  logic [DATA_W-1:0] data_out;
  logic              dut_full;
  logic              dut_empty;

  modport master (output vld_in, data_in, vld_out, data_out, dut_full, dut_empty);
  modport slave  (input  vld_in, data_in, vld_out, data_out, dut_full, dut_empty);
endinterface

// File: rtl/fifo_scoreboard_chk.sv
// FIFO reference-model checker: mirrors push/pop traffic, compares delayed read data
// and status flags, and reports sticky errors plus the first data mismatch.
module fifo_scoreboard_chk #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int RD_LAT    = 1,
  parameter int BYPASS    = 1,
  parameter int CHK_FLAGS = 1,
  parameter int CNT_W     = 8,
  localparam int OCC_W    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_b,
  fifo_scoreboard_chk_if.slave bus,
  input  logic                 clr_err,
  output logic [OCC_W-1:0]     occupancy,
  output logic                 err_overflow,
  output logic                 err_underflow,
  output logic                 err_mismatch,
  output logic                 err_flag,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [DATA_W-1:0]    first_exp,
  output logic [DATA_W-1:0]    first_act
);
  localparam int   PTR_W = $clog2(DEPTH);
  localparam logic BYP   = (BYPASS != 0);
  localparam logic CHK   = (CHK_FLAGS != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;

  logic              full, empty, overflow, underflow, bypass_pop;
  logic              push_ok, pop_ok, pop_mem, flag_bad, mismatch;
  logic [DATA_W-1:0] exp_now, cmp_exp;
  logic              cmp_vld;
  logic [CNT_W-1:0]  cnt_base;

  assign full       = (occupancy == OCC_W'(DEPTH));
  assign empty      = (occupancy == '0);
  assign overflow   = full && bus.vld_in && !bus.vld_out;
  assign underflow  = empty && bus.vld_out && !(BYP && bus.vld_in);
  assign bypass_pop = empty && BYP && bus.vld_in && bus.vld_out;
  assign pop_ok     = bus.vld_out && !underflow;
  // A fall-through pop consumes its own push, so neither touches the model storage.
  assign push_ok    = bus.vld_in && !overflow && !bypass_pop;
  assign pop_mem    = pop_ok && !bypass_pop;
  assign exp_now    = bypass_pop ? bus.data_in : mem[rd_ptr];
  assign flag_bad   = CHK && ((bus.dut_full != full) || (bus.dut_empty != empty));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= bus.data_in;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop_mem)
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push_ok, pop_mem})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  generate
    if (RD_LAT == 0) begin : g_lat0
      assign cmp_vld = pop_ok;
      assign cmp_exp = exp_now;
    end else begin : g_latn
      logic [RD_LAT-1:0] vld_pipe;
      logic [DATA_W-1:0] exp_pipe [RD_LAT];
      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          vld_pipe <= '0;
          for (int i = 0; i < RD_LAT; i++) exp_pipe[i] <= '0;
        end else begin
          vld_pipe[0] <= pop_ok;
          exp_pipe[0] <= exp_now;
          for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            exp_pipe[i] <= exp_pipe[i-1];
          end
        end
      end
      assign cmp_vld = vld_pipe[RD_LAT-1];
      assign cmp_exp = exp_pipe[RD_LAT-1];
    end
  endgenerate

  assign mismatch = cmp_vld && (cmp_exp != bus.data_out);
  // A clear in the same cycle as a mismatch restarts the count at this mismatch.
  assign cnt_base = clr_err ? '0 : err_cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_mismatch  <= 1'b0;
      err_flag      <= 1'b0;
      err_cnt       <= '0;
      first_exp     <= '0;
      first_act     <= '0;
    end else begin
      err_overflow  <= overflow  || (err_overflow  && !clr_err);
      err_underflow <= underflow || (err_underflow && !clr_err);
      err_mismatch  <= mismatch  || (err_mismatch  && !clr_err);
      err_flag      <= flag_bad  || (err_flag      && !clr_err);
      if (mismatch) begin
        err_cnt <= (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
        if (cnt_base == '0) begin
          first_exp <= cmp_exp;
          first_act <= bus.data_out;
        end
      end else if (clr_err) begin
        err_cnt   <= '0;
        first_exp <= '0;
        first_act <= '0;
      end
    end
  end

  ap_overflow: assert property (@(posedge clk) disable iff (!rst_b)
    (occupancy == OCC_W'(DEPTH) && bus.vld_in && !bus.vld_out) |=> err_overflow);
  ap_underflow: assert property (@(posedge clk) disable iff (!rst_b)
    (occupancy == '0 && bus.vld_out && !(BYP && bus.vld_in)) |=> err_underflow);
  ap_mismatch: assert property (@(posedge clk) disable iff (!rst_b)
    (cmp_vld && cmp_exp != bus.data_out) |=> err_mismatch);
endmodule
